// File: rtl/wide_add_pkg.sv
// ============================================================================
// Module   : wide_add_pkg
// Purpose  : Shared types and default sizing for the chunked sequential adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wide_add_pkg;

    // Default operand width and adder-slice width
    localparam int DEF_WIDTH = 100;
    localparam int DEF_CHUNK = 25;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : wide_add_pkg

`default_nettype wire

// File: rtl/add_slice.sv
// ============================================================================
// Module   : add_slice
// Purpose  : CHUNK-bit combinational ripple-carry adder slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_slice #(
    parameter int CHUNK = 25
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    // w_carry[i] is the carry into bit i; w_carry[CHUNK] leaves the slice
    logic [CHUNK:0] w_carry;

    assign w_carry[0] = cin;

    // One full adder per bit, chained LSB to MSB
    generate
        for (genvar i = 0; i < CHUNK; i++) begin : g_bit
            assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
            assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = w_carry[CHUNK];

endmodule : add_slice

`default_nettype wire

// File: rtl/wide_add_seq.sv
// ============================================================================
// Module   : wide_add_seq
// Purpose  : WIDTH-bit adder built by reusing one CHUNK-bit slice over
//            WIDTH/CHUNK cycles, with valid/ready on operands and result.
//            Optional macro WIDE_ADD_SEQ_SUB_EN adds a 'sub' input that turns
//            the operation into a - b (cout=1 means no borrow).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    // Width must split into whole slices
    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("wide_add_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t                                r_state;
    logic                                  r_in_ready;
    logic                                  r_out_valid;
    logic                                  r_busy;
    logic                                  r_cout;
    logic                                  r_carry;
    logic [IDX_W-1:0]                      r_idx;
    logic [NUM_CHUNKS-1:0][CHUNK-1:0]      r_a;
    logic [NUM_CHUNKS-1:0][CHUNK-1:0]      r_b;
    logic [NUM_CHUNKS-1:0][CHUNK-1:0]      r_sum;

    logic [CHUNK-1:0]                      w_slice_sum;
    logic                                  w_slice_cout;
    logic                                  w_last;
    logic [WIDTH-1:0]                      w_b_in;
    logic                                  w_carry_in;

    // Operand conditioning at the handshake: subtraction is a + ~b + 1
`ifdef WIDE_ADD_SEQ_SUB_EN
    assign w_b_in     = sub ? ~b : b;
    assign w_carry_in = sub ? 1'b1 : cin;
`else
    assign w_b_in     = b;
    assign w_carry_in = cin;
`endif

    assign w_last = (r_idx == IDX_W'(NUM_CHUNKS - 1));

    // The single shared slice, fed by the chunk selected by r_idx
    add_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a    (r_a[r_idx]),
        .b    (r_b[r_idx]),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    // Sequencer: accept operands, walk the chunks, hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= w_b_in;
                        r_carry    <= w_carry_in;
                        r_idx      <= '0;
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_sum[r_idx] <= w_slice_sum;
                    r_carry      <= w_slice_cout;
                    if (w_last) begin
                        r_cout      <= w_slice_cout;
                        r_idx       <= '0;
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_idx       <= '0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule : wide_add_seq

`default_nettype wire

// File: tb/tb_wide_add_seq.sv
// ============================================================================
// Module   : tb_wide_add_seq
// Purpose  : Self-checking bench for wide_add_seq (directed + random traffic
//            against an arithmetic reference). Honours WIDE_ADD_SEQ_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wide_add_seq;

    localparam int W  = 100;
    localparam int NC = 4;
    localparam int N_RAND = 1000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub_r;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    wide_add_seq #(
        .WIDTH (W),
        .CHUNK (25)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef WIDE_ADD_SEQ_SUB_EN
        .sub       (sub_r),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on WIDTH+1 bits
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        logic [W:0] r;
        if (s) r = {1'b0, x} - {1'b0, y} + (1 << W);
        else   r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        return r;
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            default: return r[W-1:0];
        endcase
    endfunction

    function automatic logic [W-1:0] pow2(input int n);
        logic [W-1:0] r;
        r = '0;
        r[n] = 1'b1;
        return r;
    endfunction

    // Full directed transaction with latency, stall and retire checks
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic ts, input int hold);
        logic [W:0] e;
        int n;
        e = model(ta, tb_v, tc, ts);
        a = ta; b = tb_v; cin = tc; sub_r = ts; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) check_eq({tag, " accept_timeout"}, 0, 1);
        @(posedge clk); #1;                     // handshake edge k
        in_valid = 1'b0;
        a = rand_wide(); b = rand_wide();
        for (int i = 0; i < NC; i++) begin       // edges k .. k+NC-1: running
            check_eq({tag, " run_flags{ov,ir,busy}"}, {125'd0, out_valid, in_ready, busy}, 128'd1);
            @(posedge clk); #1;
        end
        check_eq({tag, " done_flags{ov,ir,busy}"}, {125'd0, out_valid, in_ready, busy}, 128'd5);
        for (int h = 0; h < hold; h++) begin
            check_eq({tag, " hold_sum"}, {27'd0, cout, sum}, {27'd0, e});
            check_eq({tag, " hold_flags"}, {125'd0, out_valid, in_ready, busy}, 128'd5);
            @(posedge clk); #1;
        end
        check_eq({tag, " sum"}, {28'd0, sum}, {28'd0, e[W-1:0]});
        check_eq({tag, " cout"}, {127'd0, cout}, {127'd0, e[W]});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, " retire_flags"}, {125'd0, out_valid, in_ready, busy}, 128'd2);
    endtask

    initial begin
        logic [W:0] exp_q[$];
        logic [W:0] e;
        int acc, got, cyc;
        bit stray;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub_r = 1'b0;
        #23;
        check_eq("reset_flags{ov,ir,busy}", {125'd0, out_valid, in_ready, busy}, 128'd2);
        check_eq("reset_sum", {27'd0, cout, sum}, 128'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("ones_plus_cin", '1, '0, 1'b1, 1'b0, 0);
        do_op("one_plus_two_stall", 100'h1, 100'h2, 1'b0, 1'b0, 5);

        // Reset in the middle of a run
        a = pow2(99); b = pow2(99); cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrun_reset_flags", {125'd0, out_valid, in_ready, busy}, 128'd2);
        check_eq("midrun_reset_sum", {27'd0, cout, sum}, 128'd0);
        @(negedge clk); rst_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) stray = 1'b1;
        end
        check_eq("no_pulse_after_reset", {127'd0, stray}, 128'd0);
        do_op("three_plus_four", 100'd3, 100'd4, 1'b0, 1'b0, 1);

        do_op("chunk_boundary", pow2(25) - 1, 100'd1, 1'b0, 1'b0, 0);
        do_op("top_chunk_carry", pow2(75) - 1, 100'd1, 1'b0, 1'b0, 0);
        do_op("top_chunk_add", pow2(75), pow2(75), 1'b0, 1'b0, 0);
        do_op("full_overflow", '1, '1, 1'b1, 1'b0, 0);

`ifdef WIDE_ADD_SEQ_SUB_EN
        do_op("sub_5_7", 100'd5, 100'd7, 1'b0, 1'b1, 0);
        do_op("sub_7_5", 100'd7, 100'd5, 1'b1, 1'b1, 0);
`endif

        // Random traffic: scoreboard fed at each observed input handshake
        acc = 0; got = 0; cyc = 0;
        while ((acc < N_RAND || got < acc) && cyc < 60000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("rand_unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rand_sum_cout", {27'd0, cout, sum}, {27'd0, e});
                    got++;
                end
            end
            a = rand_wide(); b = rand_wide(); cin = 1'($urandom);
`ifdef WIDE_ADD_SEQ_SUB_EN
            sub_r = 1'($urandom);
`endif
            in_valid = (acc < N_RAND) && ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub_r));
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check_eq("rand_accepted", acc, N_RAND);
        check_eq("rand_retired", got, acc);
        check_eq("rand_queue_empty", exp_q.size(), 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        check_eq("idle_after_rand{ov,ir,busy}", {125'd0, out_valid, in_ready, busy}, 128'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_wide_add_seq

`default_nettype wire
